// File: rtl/flux_seq_pkg.sv
// Shared types and helpers for the spectral-flux frame sequencer.
package flux_seq_pkg;

  typedef enum logic [1:0] {
    STREAM,
    DRAIN,
    SUMMARY
  } seq_state_t;

  localparam int FRAME_CNT_W = 16;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int calc_aw(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/flux_frame_sequencer.sv
// Gates the magnitude-squared bin stream, pairs each bin with its previous-frame
// value from an external RAM, and stalls input for a summary window per frame.
module flux_frame_sequencer
  import flux_seq_pkg::*;
#(
  parameter  int N              = 1024,
  parameter  int W              = 64,
  parameter  int SUMMARY_CYCLES = 4,
  localparam int AW             = calc_aw(N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_mag,
  input  logic                   frame_abort,
  output logic                   ram_rd_en,
  output logic [AW-1:0]          ram_rd_addr,
  input  logic [W-1:0]           ram_rd_data,
  output logic                   ram_wr_en,
  output logic [AW-1:0]          ram_wr_addr,
  output logic [W-1:0]           ram_wr_data,
  output logic                   dp_valid,
  output logic [W-1:0]           dp_cur,
  output logic [W-1:0]           dp_prev,
  output logic [AW-1:0]          dp_bin,
  output logic                   dp_last,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   warm
);

  localparam int SW = calc_aw(SUMMARY_CYCLES + 1);
  localparam logic [AW-1:0] LAST_BIN = AW'(N - 1);
  localparam logic [SW-1:0] SUM_END  = SW'(SUMMARY_CYCLES - 1);

  seq_state_t             state_reg, state_next;
  logic [AW-1:0]          bin_cnt_reg, bin_cnt_next;
  logic [SW-1:0]          sum_cnt_reg, sum_cnt_next;
  logic                   pend_valid_reg;
  logic [W-1:0]           mag_reg;
  logic [AW-1:0]          bin_reg;
  logic                   frame_done_reg;
  logic                   warm_reg;
  logic [FRAME_CNT_W-1:0] frame_count_reg;
  logic                   accept;

  always_comb begin
    state_next   = state_reg;
    bin_cnt_next = bin_cnt_reg;
    sum_cnt_next = sum_cnt_reg;
    in_ready     = (state_reg == STREAM) && !frame_abort && !reset;
    accept       = in_ready && in_valid;

    case (state_reg)
      STREAM: begin
        if (accept) begin
          if (bin_cnt_reg == LAST_BIN) begin
            bin_cnt_next = '0;
            state_next   = DRAIN;
          end else begin
            bin_cnt_next = bin_cnt_reg + AW'(1);
          end
        end
      end
      DRAIN: state_next = SUMMARY;
      SUMMARY: begin
        if (sum_cnt_reg == SUM_END) begin
          sum_cnt_next = '0;
          state_next   = STREAM;
        end else begin
          sum_cnt_next = sum_cnt_reg + SW'(1);
        end
      end
      default: state_next = STREAM;
    endcase

    // Abort discards the partial frame from any state.
    if (frame_abort) begin
      state_next   = STREAM;
      bin_cnt_next = '0;
      sum_cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= STREAM;
      bin_cnt_reg     <= '0;
      sum_cnt_reg     <= '0;
      pend_valid_reg  <= 1'b0;
      mag_reg         <= '0;
      bin_reg         <= '0;
      frame_done_reg  <= 1'b0;
      warm_reg        <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      bin_cnt_reg    <= bin_cnt_next;
      sum_cnt_reg    <= sum_cnt_next;
      pend_valid_reg <= accept;
      if (accept) begin
        mag_reg <= in_mag;
        bin_reg <= bin_cnt_reg;
      end
      // The pulse lands on the SUMMARY entry cycle; an abort there cannot retract it.
      frame_done_reg <= (state_reg == DRAIN) && !frame_abort;
      if (frame_done_reg) frame_count_reg <= frame_count_reg + FRAME_CNT_W'(1);
      if (frame_abort) warm_reg <= 1'b0;
      else if (frame_done_reg) warm_reg <= 1'b1;
    end
  end

  assign ram_rd_en   = accept;
  assign ram_rd_addr = accept ? bin_cnt_reg : '0;

  // Read of bin b+1 and write of bin b share a cycle but never an address.
  assign ram_wr_en   = pend_valid_reg;
  assign ram_wr_addr = pend_valid_reg ? bin_reg : '0;
  assign ram_wr_data = pend_valid_reg ? mag_reg : '0;

  assign dp_valid    = pend_valid_reg;
  assign dp_cur      = pend_valid_reg ? mag_reg : '0;
  assign dp_bin      = pend_valid_reg ? bin_reg : '0;
  assign dp_last     = pend_valid_reg && (bin_reg == LAST_BIN);
  assign dp_prev     = (pend_valid_reg && warm_reg) ? ram_rd_data : '0;

  assign frame_done  = frame_done_reg;
  assign frame_count = frame_count_reg;
  assign warm        = warm_reg;

endmodule

// File: doc/flux_frame_sequencer.md
Name: flux_frame_sequencer

Overview:
Sequences the magnitude-squared bin stream into the spectral-flux datapath. It gates input with a valid/ready handshake and counts bins per frame. It schedules read-before-write access to the external previous-frame magnitude RAM and presents aligned current/previous pairs to the flux arithmetic. At each frame boundary it stalls input for a fixed summary window, during which the flux history and threshold update.

Parameters:
N, 1024, bins per frame (power of two, >=4)
W, 64, magnitude-squared width
SUMMARY_CYCLES, 4, input-stall cycles after frame_done (>=1)
AW, $clog2(N), bin address width (derived, not overridable)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  magnitude sample valid
in_ready  out  1  sequencer can accept a sample
in_mag  in  W  magnitude-squared sample
frame_abort  in  1  discard the partial frame
ram_rd_en  out  1  previous-magnitude RAM read strobe
ram_rd_addr  out  AW  read address
ram_rd_data  in  W  read data, valid 1 cycle after ram_rd_en
ram_wr_en  out  1  write strobe
ram_wr_addr  out  AW  write address
ram_wr_data  out  W  write data
dp_valid  out  1  aligned pair valid to flux datapath
dp_cur  out  W  current-frame magnitude
dp_prev  out  W  previous-frame magnitude (0 when warm=0)
dp_bin  out  AW  bin index of pair
dp_last  out  1  pair is bin N-1
frame_done  out  1  one-cycle pulse, frame complete
frame_count  out  16  completed frames, wraps
warm  out  1  RAM holds one full valid frame

Behaviour:
- States: STREAM, DRAIN, SUMMARY. Enum lives in the package.
- Reset:
  - state=STREAM, bin_cnt=0, dp_valid=0, frame_done=0, warm=0, frame_count=0, summary counter=0.
  - All data outputs are 0. in_ready=0 while reset is high.
- in_ready is high only when state==STREAM && !frame_abort && !reset.
- An accept is in_valid && in_ready in cycle t. That cycle, combinationally: ram_rd_en=1, ram_rd_addr=bin_cnt. in_mag and bin_cnt are registered.
- In cycle t+1:
  - dp_valid=1, dp_cur=registered mag, dp_bin=registered bin, dp_last=(bin==N-1).
  - dp_prev = warm ? ram_rd_data : 0.
  - ram_wr_en=1, ram_wr_addr=dp_bin, ram_wr_data=dp_cur.
  - Latency is 1 cycle from accept to dp_valid.
- The write in t+1 and the read of the next bin in t+1 always target different addresses. Across the frame wrap this is write N-1 and read 0. No RAM hazard arises.
- in_valid gaps: bin_cnt holds and dp_valid drops for the gap. There is no timeout.
- Accepting bin N-1 sets bin_cnt to 0 and moves the state to DRAIN.
- DRAIN (1 cycle): in_ready=0 and the bin N-1 pair is emitted. Next state is SUMMARY.
- SUMMARY entry cycle:
  - frame_done=1 for exactly one cycle.
  - frame_count increments, wrapping 0xFFFF→0.
  - warm becomes 1 from the next cycle.
- SUMMARY holds in_ready=0 for SUMMARY_CYCLES cycles, counting the entry cycle, then returns to STREAM.
- Throughput: at most N samples per N+1+SUMMARY_CYCLES cycles.
- frame_abort, any state:
  - Next state is STREAM and bin_cnt=0.
  - A pending pair is suppressed: dp_valid=0 and ram_wr_en=0 next cycle. An accept in the same cycle is blocked.
  - warm is cleared, because the RAM is partially overwritten.
  - No frame_done is issued. If abort hits the SUMMARY entry cycle, frame_done is still asserted that cycle and frame_count still increments.
- Abort priority is highest after reset. Accept has priority over the summary counter.
- Reset mid-frame returns all state to the reset values on the next edge. RAM contents are ignored because warm=0.

Decomposition:
- Package flux_seq_pkg holds:
  - state enum seq_state_t {STREAM, DRAIN, SUMMARY};
  - FRAME_CNT_W=16;
  - a localparam function computing AW.
- No sub-module. The previous-magnitude RAM stays external so the same dual-port memory can be shared or swapped for block RAM. The flux arithmetic remains in the spectral-flux datapath.

Test Plan:
- First frame: N=8, SUMMARY_CYCLES=4, send mags 1..8 back-to-back. Expect:
  - dp_valid 1 cycle after each accept;
  - dp_prev=0 for all bins and dp_last on bin 7;
  - frame_done pulses 2 cycles after the bin-7 accept;
  - in_ready low exactly 5 cycles, then frame_count=1 and warm=1.
- Second frame: send 10..17. Expect dp_cur=10..17 with dp_prev=1..8 at matching dp_bin, and RAM writes of 10..17 at addresses 0..7.
- Gaps: in_valid toggled 1010… across a frame. Expect identical pairs with no skipped or duplicated bin, and frame_done only after 8 accepts.
- Abort: frame_abort asserted after bin 3 of the third frame. Expect:
  - no write or dp_valid for the pending bin and no frame_done;
  - warm=0;
  - the next sample lands at bin 0 with dp_prev=0.
- Backpressure: in_valid held high during DRAIN/SUMMARY. Expect no accepts, and the first accept in the cycle in_ready returns with bin=0.
- Reset mid-frame after bin 5. Expect all outputs at their reset values, frame_count=0, and the next frame treated as a first frame (dp_prev=0).
